// File: rtl/memory_read_pixel_extractor.sv
// memory_read_pixel_extractor
//   Pairs the fetch stream (pixel indices) with the AXI R beats produced by the
//   companion request generator. It keeps one STREAM_WIDTH-bit line plus its tag.
//   A fetch that hits the line returns its pixel one cycle after it is accepted.
//   A fetch that misses waits for the next R beat. That beat refills the line,
//   and the pixel comes straight out of rdata.
//
//   Ports:
//     aclk, resetn            clock, async active-low reset
//     s_fetch_axis_*          fetch stream in (tdest = pixel index, tlast = group end)
//     s_mem_axi_r*            AXI read-data channel in (single-beat bursts)
//     m_pixel_axis_*          pixel stream out (tlast copied from the fetch)
//     error                   sticky protocol error flag
//
//   Optional feature macro: MEMORY_READ_PIXEL_ERROR_CHECK_EN
//     defined   : error is set on an rid/rresp/rlast mismatch
//     undefined : error tied low and rid/rresp/rlast are ignored
module memory_read_pixel_extractor #(
  parameter int STREAM_WIDTH = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int ID_WIDTH     = 8,
  parameter int PIXEL_WIDTH  = 16
) (
  input  logic                    aclk,
  input  logic                    resetn,
  input  logic                    s_fetch_axis_tvalid,
  output logic                    s_fetch_axis_tready,
  input  logic                    s_fetch_axis_tlast,
  input  logic [ADDR_WIDTH-1:0]   s_fetch_axis_tdest,
  input  logic [ID_WIDTH-1:0]     s_mem_axi_rid,
  input  logic [STREAM_WIDTH-1:0] s_mem_axi_rdata,
  input  logic [1:0]              s_mem_axi_rresp,
  input  logic                    s_mem_axi_rlast,
  input  logic                    s_mem_axi_rvalid,
  output logic                    s_mem_axi_rready,
  output logic                    m_pixel_axis_tvalid,
  input  logic                    m_pixel_axis_tready,
  output logic                    m_pixel_axis_tlast,
  output logic [PIXEL_WIDTH-1:0]  m_pixel_axis_tdata,
  output logic                    error
);

  localparam int NPIX   = STREAM_WIDTH / PIXEL_WIDTH;
  localparam int IDX_W  = $clog2(NPIX);
  localparam int IDX_WS = (IDX_W > 0) ? IDX_W : 1;
  localparam int TAG_W  = ADDR_WIDTH - IDX_W;

  typedef enum logic {S_IDLE, S_WAIT_BEAT} state_t;

  state_t                  r_state, w_next_state;
  logic [STREAM_WIDTH-1:0] r_line;
  logic [TAG_W-1:0]        r_line_tag;
  logic                    r_line_valid;
  logic [TAG_W-1:0]        r_tag;     // tag of the fetch that is waiting for a beat
  logic [IDX_WS-1:0]       r_idx;
  logic                    r_tlast;
  logic                    r_out_valid;
  logic                    r_out_last;
  logic [PIXEL_WIDTH-1:0]  r_out_data;

  logic [TAG_W-1:0]        w_fetch_tag;
  logic [IDX_WS-1:0]       w_fetch_idx;
  logic [PIXEL_WIDTH-1:0]  w_hit_pix, w_beat_pix;
  logic                    w_out_free, w_hit;
  logic                    w_fetch_ready, w_rready;
  logic                    w_fetch_acc, w_beat_acc;

  logic [NPIX-1:0][PIXEL_WIDTH-1:0] w_line_pix, w_rdata_pix;
  assign w_line_pix  = r_line;
  assign w_rdata_pix = s_mem_axi_rdata;
  assign w_fetch_tag = s_fetch_axis_tdest[ADDR_WIDTH-1:IDX_W];

  // When a line holds only one pixel there is no index field.
  generate
    if (IDX_W > 0) begin : g_idx
      assign w_fetch_idx = s_fetch_axis_tdest[IDX_W-1:0];
      assign w_hit_pix   = w_line_pix[w_fetch_idx];
      assign w_beat_pix  = w_rdata_pix[r_idx];
    end else begin : g_noidx
      assign w_fetch_idx = '0;
      assign w_hit_pix   = w_line_pix[0];
      assign w_beat_pix  = w_rdata_pix[0];
    end
  endgenerate

  // The output register is free if it is empty or is drained this cycle.
  assign w_out_free = !r_out_valid || m_pixel_axis_tready;
  assign w_hit      = r_line_valid && (w_fetch_tag == r_line_tag);

  always_comb begin
    w_next_state  = r_state;
    w_fetch_ready = 1'b0;
    w_rready      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_fetch_ready = w_out_free;
        if (s_fetch_axis_tvalid && w_out_free && !w_hit) w_next_state = S_WAIT_BEAT;
      end
      S_WAIT_BEAT: begin
        // Hold off a beat until its pixel has somewhere to go. The beat then
        // stalls on the bus and is never dropped.
        w_rready = w_out_free;
        if (s_mem_axi_rvalid && w_out_free) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_fetch_acc = s_fetch_axis_tvalid && w_fetch_ready;
  assign w_beat_acc  = s_mem_axi_rvalid && w_rready;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_line       <= '0;
      r_line_tag   <= '0;
      r_line_valid <= 1'b0;
      r_tag        <= '0;
      r_idx        <= '0;
      r_tlast      <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_data   <= '0;
    end else begin
      if (w_fetch_acc && w_hit) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_hit_pix;
        r_out_last  <= s_fetch_axis_tlast;
        // A group end drops the line, so the next fetch misses. This matches the
        // generator resetting its tag and keeps beats paired 1:1 with requests.
        if (s_fetch_axis_tlast) r_line_valid <= 1'b0;
      end else if (w_beat_acc) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= w_beat_pix;
        r_out_last   <= r_tlast;
        r_line       <= s_mem_axi_rdata;
        r_line_tag   <= r_tag;
        r_line_valid <= !r_tlast;
      end else if (m_pixel_axis_tready) begin
        r_out_valid <= 1'b0;
      end
      if (w_fetch_acc && !w_hit) begin
        r_tag   <= w_fetch_tag;
        r_idx   <= w_fetch_idx;
        r_tlast <= s_fetch_axis_tlast;
      end
    end
  end

  assign s_fetch_axis_tready = w_fetch_ready;
  assign s_mem_axi_rready    = w_rready;
  assign m_pixel_axis_tvalid = r_out_valid;
  assign m_pixel_axis_tlast  = r_out_last;
  assign m_pixel_axis_tdata  = r_out_data;

`ifdef MEMORY_READ_PIXEL_ERROR_CHECK_EN
  // The generator issues arid 1, 2, 3, ... in order, so each beat must carry
  // the next ID in that sequence.
  logic [ID_WIDTH-1:0] r_exp_id;
  logic                r_err;
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_exp_id <= ID_WIDTH'(1);
      r_err    <= 1'b0;
    end else if (w_beat_acc) begin
      r_exp_id <= r_exp_id + 1'b1;
      if (s_mem_axi_rid != r_exp_id || s_mem_axi_rresp != 2'b00 || !s_mem_axi_rlast)
        r_err <= 1'b1;
    end
  end
  assign error = r_err;
`else
  logic w_unused_rchk;
  assign w_unused_rchk = ^{s_mem_axi_rid, s_mem_axi_rresp, s_mem_axi_rlast};
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_memory_read_pixel_extractor.sv
module tb_memory_read_pixel_extractor;

`ifdef MEMORY_READ_PIXEL_ERROR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        resetn;
  logic        f_tvalid, f_tready, f_tlast;
  logic [31:0] f_tdest;
  logic [7:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        p_tvalid, p_tready, p_tlast;
  logic [15:0] p_tdata;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  memory_read_pixel_extractor #(
    .STREAM_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(8), .PIXEL_WIDTH(16)
  ) dut (
    .aclk(aclk), .resetn(resetn),
    .s_fetch_axis_tvalid(f_tvalid), .s_fetch_axis_tready(f_tready),
    .s_fetch_axis_tlast(f_tlast), .s_fetch_axis_tdest(f_tdest),
    .s_mem_axi_rid(rid), .s_mem_axi_rdata(rdata), .s_mem_axi_rresp(rresp),
    .s_mem_axi_rlast(rlast), .s_mem_axi_rvalid(rvalid), .s_mem_axi_rready(rready),
    .m_pixel_axis_tvalid(p_tvalid), .m_pixel_axis_tready(p_tready),
    .m_pixel_axis_tlast(p_tlast), .m_pixel_axis_tdata(p_tdata),
    .error(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step to 1 time unit after the next rising edge, away from the sampling point.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] dest, input logic last);
    f_tvalid = 1'b1; f_tdest = dest; f_tlast = last;
  endtask

  task automatic beat(input logic [31:0] d, input logic [7:0] id, input logic [1:0] resp);
    rvalid = 1'b1; rdata = d; rid = id; rresp = resp; rlast = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; f_tvalid = 1'b0; f_tlast = 1'b0; f_tdest = '0;
    rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0; p_tready = 1'b0;
    #12;
    chk("rst_fetch_tready", {31'd0, f_tready}, 32'd1);
    chk("rst_rready",       {31'd0, rready},   32'd0);
    chk("rst_tvalid",       {31'd0, p_tvalid}, 32'd0);
    chk("rst_tdata",        {16'd0, p_tdata},  32'd0);
    chk("rst_tlast",        {31'd0, p_tlast},  32'd0);
    chk("rst_error",        {31'd0, err},      32'd0);
    resetn = 1'b1; p_tready = 1'b1;

    // Miss on tdest=4 (tag 2, idx 0).
    tick(); fetch(32'd4, 1'b0); #1;
    chk("miss_accept_rdy", {31'd0, f_tready}, 32'd1);
    tick(); f_tvalid = 1'b0; #1;
    chk("wait_fetch_tready", {31'd0, f_tready}, 32'd0);
    chk("wait_rready",       {31'd0, rready},   32'd1);
    chk("wait_no_pixel",     {31'd0, p_tvalid}, 32'd0);
    beat(32'hBBBBAAAA, 8'd1, 2'b00);
    tick(); rvalid = 1'b0; #1;
    chk("miss_tvalid", {31'd0, p_tvalid}, 32'd1);
    chk("miss_tdata",  {16'd0, p_tdata},  32'h0000AAAA);
    chk("miss_tlast",  {31'd0, p_tlast},  32'd0);

    // Hit on tdest=5 (idx 1); no beat is taken.
    fetch(32'd5, 1'b0); #1;
    chk("hit_rready", {31'd0, rready}, 32'd0);
    tick(); #1;
    chk("hit_tdata",  {16'd0, p_tdata},  32'h0000BBBB);
    chk("hit_tvalid", {31'd0, p_tvalid}, 32'd1);

    // tlast hit invalidates the line; the following same-tag fetch misses.
    fetch(32'd5, 1'b1);
    tick(); #1;
    chk("tl_hit_tdata", {16'd0, p_tdata}, 32'h0000BBBB);
    chk("tl_hit_tlast", {31'd0, p_tlast}, 32'd1);
    fetch(32'd5, 1'b0);
    tick(); f_tvalid = 1'b0; #1;
    chk("tl_miss_rready", {31'd0, rready},   32'd1);
    chk("tl_miss_tready", {31'd0, f_tready}, 32'd0);
    chk("tl_out_drained", {31'd0, p_tvalid}, 32'd0);
    beat(32'h22221111, 8'd2, 2'b00);
    tick(); rvalid = 1'b0; #1;
    chk("tl_refill_tdata", {16'd0, p_tdata}, 32'h00002222);
    chk("tl_refill_tlast", {31'd0, p_tlast}, 32'd0);

    // Backpressure: pixel 0x2222 is stuck while a hit for tdest=4 waits.
    p_tready = 1'b0; fetch(32'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_fetch_tready", {31'd0, f_tready}, 32'd0);
      chk("bp_tdata_held",   {16'd0, p_tdata},  32'h00002222);
      chk("bp_tvalid_held",  {31'd0, p_tvalid}, 32'd1);
      tick();
    end
    p_tready = 1'b1; #1;
    chk("bp_release_tready", {31'd0, f_tready}, 32'd1);
    tick(); f_tvalid = 1'b0; #1;
    chk("bp_next_tvalid", {31'd0, p_tvalid}, 32'd1);
    chk("bp_next_tdata",  {16'd0, p_tdata},  32'h00001111);
    tick(); #1;
    chk("bp_drained", {31'd0, p_tvalid}, 32'd0);

    // Reset while waiting for a beat.
    fetch(32'd100, 1'b0);
    tick(); f_tvalid = 1'b0; #1;
    chk("rw_rready_before", {31'd0, rready}, 32'd1);
    beat(32'h33334444, 8'd1, 2'b00);
    resetn = 1'b0; #1;
    chk("rw_rready_async",  {31'd0, rready},   32'd0);
    chk("rw_ftready_async", {31'd0, f_tready}, 32'd1);
    chk("rw_tvalid_async",  {31'd0, p_tvalid}, 32'd0);
    #2; resetn = 1'b1;
    tick(); tick(); #1;
    chk("rw_beat_held_rdy",    {31'd0, rready},   32'd0);
    chk("rw_beat_held_tvalid", {31'd0, p_tvalid}, 32'd0);
    fetch(32'd101, 1'b0);
    tick(); f_tvalid = 1'b0;
    tick(); rvalid = 1'b0; #1;
    chk("rw_new_miss_tdata",  {16'd0, p_tdata},  32'h00003333);
    chk("rw_new_miss_tvalid", {31'd0, p_tvalid}, 32'd1);
    chk("rw_err_clean",       {31'd0, err},      32'd0);

    // Wrong rid (3 while 2 is expected), then a clean beat: the flag must stick.
    fetch(32'd200, 1'b0);
    tick(); f_tvalid = 1'b0;
    beat(32'h55556666, 8'd3, 2'b00);
    tick(); rvalid = 1'b0; #1;
    chk("err_rid",       {31'd0, err},     32'(ERR_EN));
    chk("err_rid_tdata", {16'd0, p_tdata}, 32'h00006666);
    fetch(32'd300, 1'b0);
    tick(); f_tvalid = 1'b0;
    beat(32'h77778888, 8'd3, 2'b00);
    tick(); rvalid = 1'b0; #1;
    chk("err_sticky", {31'd0, err}, 32'(ERR_EN));

    // Bad rresp with a correct rid.
    resetn = 1'b0; #2;
    chk("err_cleared", {31'd0, err}, 32'd0);
    resetn = 1'b1;
    tick(); fetch(32'd7, 1'b0);
    tick(); f_tvalid = 1'b0;
    beat(32'h9999AAAA, 8'd1, 2'b10);
    tick(); rvalid = 1'b0; #1;
    chk("err_rresp",       {31'd0, err},     32'(ERR_EN));
    chk("err_rresp_tdata", {16'd0, p_tdata}, 32'h00009999);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
